// File: rtl/spike_log_pkg.sv
// rtl/spike_log_pkg.sv - event byte layout constants and encode helper for the spike event logger
package spike_log_pkg;

  localparam int         EV_S1_BIT = 7;
  localparam int         EV_S2_BIT = 6;
  localparam int         EV_TS_MSB = 5;
  localparam logic [7:0] EV_MARKER = 8'h00;
  localparam logic [7:0] DROP_MAX  = 8'd255;

  // Real events always carry at least one flag, so they never collide with EV_MARKER.
  function automatic logic [7:0] encode_event(input logic s1, input logic s2,
                                              input logic [EV_TS_MSB:0] ts);
    logic [7:0] ev;
    ev = '0;
    ev[EV_S1_BIT] = s1;
    ev[EV_S2_BIT] = s2;
    ev[EV_TS_MSB:0] = ts;
    return ev;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with full-with-pop acceptance and drop flag
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_req_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             empty, full, do_pop, do_push;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  // ev_ready is ignored while empty; a pop on a full FIFO makes room for the same-cycle push.
  assign do_pop  = pop_req_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  assign valid_o = !empty;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Next pointer and occupancy values from the accepted push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer/occupancy registers; reset flushes and discards any push or pop in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/spike_event_logger.sv
// rtl/spike_event_logger.sv - timestamps neuron spikes into a byte FIFO with overflow accounting
module spike_event_logger
  import spike_log_pkg::*;
#(
  parameter int TS_WIDTH = 6,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   spike1,
  input  logic                   spike2,
  input  logic                   ev_ready,
  output logic                   ev_valid,
  output logic [7:0]             ev_data,
  input  logic                   clear_stat,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic [$clog2(DEPTH):0] level
);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_q, drop_d;
  logic                spike_any, push, drop;
  logic [7:0]          push_word;

  assign spike_any = spike1 | spike2;
  // A spike at ts==0 replaces the wrap marker rather than adding to it.
  assign push      = en && (spike_any || (ts_q == '0));
  assign push_word = spike_any ? encode_event(spike1, spike2, ts_q) : EV_MARKER;
  assign ts_d      = en ? ts_q + 1'b1 : ts_q;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_req_i   (ev_ready),
    .valid_o     (ev_valid),
    .head_o      (ev_data),
    .level_o     (level),
    .drop_o      (drop)
  );

  // Drop statistics; a drop in the same cycle as clear_stat wins and restarts the count at 1.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_stat)            drop_d = 8'd1;
      else if (drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
    end else if (clear_stat) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  // Timestamp counter and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// tb/tb_spike_event_logger.sv - self-checking bench for spike_event_logger against a queue model
module tb_spike_event_logger;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, en, spike1, spike2, ev_ready, clear_stat;
  logic       ev_valid, overflow;
  logic [7:0] ev_data, drop_count;
  logic [3:0] level;

  int total = 0;
  int bad   = 0;

  int         m_ts;
  logic [7:0] m_q[$];
  logic       m_ovf;
  int         m_drops;

  spike_event_logger #(.TS_WIDTH(6), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .spike1     (spike1),
    .spike2     (spike2),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .clear_stat (clear_stat),
    .overflow   (overflow),
    .drop_count (drop_count),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic s1, input logic s2,
                            input logic rdy, input logic clr);
    logic       pop, push, dropped;
    logic [7:0] word;
    if (r) begin
      m_ts = 0;
      m_q.delete();
      m_ovf = 1'b0;
      m_drops = 0;
      return;
    end
    pop  = rdy && (m_q.size() > 0);
    push = e && (s1 || s2 || m_ts == 0);
    word = (s1 || s2) ? ((s1 ? 8'd128 : 8'd0) + (s2 ? 8'd64 : 8'd0) + 8'(m_ts)) : 8'h00;
    dropped = push && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !dropped) m_q.push_back(word);
    if (dropped) begin
      m_ovf = 1'b1;
      m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
    if (e) m_ts = (m_ts + 1) % 64;
  endtask

  task automatic check_all();
    chk("valid", ev_valid, (m_q.size() > 0) ? 1 : 0);
    chk("data", ev_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("level", level, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
  endtask

  task automatic step(input logic r, input logic e, input logic s1, input logic s2,
                      input logic rdy, input logic clr);
    reset = r; en = e; spike1 = s1; spike2 = s2; ev_ready = rdy; clear_stat = clr;
    @(posedge clk);
    model_step(r, e, s1, s2, rdy, clr);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; spike1 = 1'b0; spike2 = 1'b0; ev_ready = 1'b0; clear_stat = 1'b0;
    m_ts = 0; m_ovf = 1'b0; m_drops = 0;

    // reset then idle: markers at ts=0 after reset and after wrap
    step(1, 1, 0, 0, 0, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_data", ev_data, 8'h00);
    chk("rst_level", level, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("idle_first_marker_level", level, 1);
    chk("idle_first_marker_data", ev_data, 8'h00);
    for (int i = 0; i < 63; i++) step(0, 1, 0, 0, 0, 0);
    chk("idle_no_extra_marker", level, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("idle_wrap_marker_level", level, 2);

    // single and simultaneous spikes with ev_ready high
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    chk("spike1_ts5", ev_data, 8'h85);
    step(0, 1, 0, 0, 1, 0);
    chk("spike1_pulse", ev_valid, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    chk("both_ts9", ev_data, 8'hC9);
    step(0, 1, 0, 0, 1, 0);
    chk("both_pulse", ev_valid, 0);

    // backpressure and overflow
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 1, 0, 0);
    chk("bp_level", level, 8);
    chk("bp_overflow", overflow, 1);
    chk("bp_drops", drop_count, 4);
    chk("bp_head", ev_data, 8'h41);

    // full with concurrent push and pop
    step(0, 1, 1, 0, 1, 0);
    chk("fullpp_level", level, 8);
    chk("fullpp_drops", drop_count, 4);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0);
    chk("fullpp_tail", ev_data, 8'h8D);
    chk("fullpp_tail_level", level, 1);

    // saturation and clear/drop collision
    for (int i = 0; i < 320; i++) step(0, 1, 1, 0, 0, 0);
    chk("sat_drops", drop_count, 255);
    step(0, 1, 1, 0, 0, 1);
    chk("clr_drop_count", drop_count, 1);
    chk("clr_drop_ovf", overflow, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("clr_only_count", drop_count, 0);
    chk("clr_only_ovf", overflow, 0);

    // reset mid-stream and enable gating
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
    chk("mid_level5", level, 5);
    step(1, 1, 1, 1, 1, 0);
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_data", ev_data, 8'h00);
    chk("mid_rst_level", level, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0, 0);
    chk("en_off_level", level, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("en_on_ts_frozen", ev_data, 8'h80);

    // randomized traffic with shifting consumer pressure
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 500) % 3 == 0) ? 20 : (((i / 500) % 3 == 1) ? 90 : 50);
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_event_logger.md
# spike_event_logger

Downstream consumer of the two-neuron STDP pair. Samples `spike1`/`spike2` every cycle, tags each spike cycle with a 6-bit wrapping timestamp, and buffers the resulting event bytes in a small FIFO. The FIFO drains over a valid/ready byte stream, so an off-chip reader or the output mux can reconstruct spike timing without cycle-exact polling. Overflow is counted and flagged rather than stalling the neurons.

## Interface
Parameters:
- `TS_WIDTH`, 6: timestamp width; event byte = 2 flag bits + `TS_WIDTH`, so fixed at 6 for 8-bit events.
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; sampled on rising `clk`.
- `en` input 1: when low, the timestamp counter holds and no events or markers are pushed; pops still allowed.
- `spike1` input 1: presynaptic neuron spike, one-cycle pulse.
- `spike2` input 1: postsynaptic neuron spike, one-cycle pulse.
- `ev_ready` input 1: consumer accepts `ev_data` when high with `ev_valid`.
- `ev_valid` output 1: FIFO non-empty.
- `ev_data` output 8: head entry `{spike1, spike2, ts[5:0]}`; 8'h00 when empty.
- `clear_stat` input 1: one-cycle pulse; clears `overflow` and `drop_count`.
- `overflow` output 1: sticky; set on any dropped push.
- `drop_count` output 8: dropped pushes, saturating at 255.
- `level` output `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- **Timestamp counter `ts`**
  - Increments by 1 each cycle with `en`=1; wraps 63→0.
  - Resets to 0.
- **Event push** (cycle with `en`=1 and `spike1|spike2`)
  - Push `{spike1, spike2, ts}`, where `ts` is the pre-increment value.
  - Simultaneous spikes produce one word with both flags set.
- **Wrap marker**
  - In a cycle with `en`=1, `ts`==0 and no spike, push 8'h00.
  - This is unambiguous, since real events always carry at least one flag.
  - If a spike occurs at `ts`==0, push only the event word; no marker.
- **Pop**: occurs when `ev_valid && ev_ready`; the head advances.
- **Simultaneous push and pop**
  - Always legal, including when full.
  - When full, the pop frees the slot and the push is accepted; `level` is unchanged.
- **Full with push and no pop**
  - Word dropped.
  - `overflow` set to 1.
  - `drop_count` incremented, saturating at 255.
  - FIFO contents unchanged.
- **Empty with pop request**: no effect; `ev_ready` is ignored while `ev_valid`=0.
- **`clear_stat`**
  - Clears `overflow` and `drop_count` to 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow`=1, `drop_count`=1.
- **Reset** (including mid-stream)
  - FIFO flushed: pointers 0, `level` 0.
  - `ts`=0, `overflow`=0, `drop_count`=0, `ev_valid`=0, `ev_data`=8'h00.
  - Pushes and pops presented in the reset cycle are ignored.

## Timing
- First-word fall-through.
  - A push at edge N into an empty FIFO gives `ev_valid`=1 and `ev_data` valid immediately after edge N: 1-cycle latency.
- `ev_data` is stable while `ev_valid`=1 and `ev_ready`=0 (no change without a pop).
- `level`, `overflow` and `drop_count` are registered and reflect edge N's push/pop/drop after edge N.
- No combinational path from `ev_ready` to `ev_valid` or `ev_data`.
  - `ev_data` is combinational only from the registered head pointer and memory.
- Throughput: one push and one pop per cycle.

## Structure
- Package `spike_log_pkg`:
  - `EV_S1_BIT`=7, `EV_S2_BIT`=6.
  - `EV_TS_MSB`=5.
  - `EV_MARKER`=8'h00.
  - `DROP_MAX`=8'd255.
- Sub-module `sync_fifo`, parameterised width/depth, FWFT, owning the full/empty/level logic and the push-when-full-with-pop rule.
- Top-level `spike_event_logger` holds the timestamp counter, event/marker encode, drop accounting and stats clear.

## Test plan
- **Reset then idle:** reset, `en`=1, no spikes, `ev_ready`=0 for 64 cycles.
  - One marker 8'h00 at `level`=1 (the `ts`=0 cycle after reset).
  - `ts` wraps back to 0 on cycle 64, giving a second marker, `level`=2.
- **Single and simultaneous spikes:** `spike1` at `ts`=5; both spikes at `ts`=9; `ev_ready`=1.
  - `ev_data` 8'h85 one cycle after the first, then 8'hC9.
  - `ev_valid` pulses for 1 cycle each.
- **Backpressure and overflow:** `ev_ready`=0, `spike2` every cycle for 12 cycles starting `ts`=1, `DEPTH`=8.
  - `level`=8.
  - `overflow`=1, `drop_count`=4.
  - Head stays 8'h41.
- **Full with concurrent push/pop:** with the FIFO full, assert `ev_ready`=1 and `spike1` in the same cycle.
  - `level` stays 8 and `drop_count` does not increment.
  - The new word appears at the tail after 7 further pops.
- **Clear/drop collision and saturation:** force 300 drops.
  - `drop_count`=255.
  - `clear_stat` coinciding with a drop gives `drop_count`=1, `overflow`=1.
- **Reset mid-stream and enable gating:** with `level`=5, pulse `reset`.
  - Next cycle: `ev_valid`=0, `ev_data`=8'h00, `level`=0.
  - `en`=0 with spikes: nothing pushed, `ts` frozen.
